// File: rtl/matrix_scan_selector_if.sv
// Control-side bus of the matrix position selector: load/scan requests in,
// linear select, one-hot enable and status pulses out.
interface matrix_scan_selector_if #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int CW   = 3,
  parameter int RW   = 3,
  parameter int SW   = 4
);
  logic                 load;
  logic [CW-1:0]        col_in;
  logic [RW-1:0]        row_in;
  logic                 scan_en;
  logic [SW-1:0]        sel;
  logic [ROWS*COLS-1:0] onehot;
  logic                 sel_valid;
  logic                 err;
  logic                 wrap;

  modport master (
    output load, col_in, row_in, scan_en,
    input  sel, onehot, sel_valid, err, wrap
  );

  modport slave (
    input  load, col_in, row_in, scan_en,
    output sel, onehot, sel_valid, err, wrap
  );
endinterface

// File: rtl/matrix_scan_selector.sv
// Holds a (col,row) matrix position, either loaded directly or auto-scanned
// with a programmable dwell, and decodes it to a linear select and one-hot enable.
module matrix_scan_selector #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int CW   = 3,
  parameter int RW   = 3,
  parameter int SW   = 4,
  parameter int DIV  = 4
) (
  input logic clk,
  input logic rst,
  matrix_scan_selector_if.slave bus
);
  localparam int N    = ROWS * COLS;
  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [CNTW-1:0] cnt;
  logic            err_q;
  logic            wrap_q;
  logic            in_range;
  logic            valid;
  logic [SW-1:0]   sel_w;

  assign in_range = (32'(bus.col_in) < COLS) && (32'(bus.row_in) < ROWS);
  assign valid    = (state == HOLD) || (state == SCAN);
  // row < ROWS and col < COLS always, so the product fits in SW bits
  assign sel_w    = SW'(row) * SW'(COLS) + SW'(col);

  assign bus.sel       = sel_w;
  assign bus.sel_valid = valid;
  assign bus.err       = err_q;
  assign bus.wrap      = wrap_q;

  for (genvar i = 0; i < N; i++) begin : g_onehot
    assign bus.onehot[i] = valid && (sel_w == SW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          // scan request wins; a coincident load is dropped silently
          if (bus.scan_en) begin
            state <= SCAN;
            col   <= '0;
            row   <= '0;
            cnt   <= '0;
          end else if (bus.load) begin
            if (in_range) begin
              col   <= bus.col_in;
              row   <= bus.row_in;
              state <= HOLD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (!bus.scan_en) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == CNTW'(DIV - 1)) begin
            cnt <= '0;
            if (col == CW'(COLS - 1)) begin
              col <= '0;
              if (row == RW'(ROWS - 1)) begin
                row    <= '0;
                wrap_q <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
